multicycle_control: RTL and testbench
=====================================

# multicycle_control

Control unit for the multicycle RISC-V core. It is a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath select and write enable, including `immSrc`, which feeds the `src` input of the sign extender that builds `inmExt` from instruction bits [31:7]. It also contains the ALU decoder that turns `aluOp`/`funct3`/`funct7b5` into `aluControl`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  instruction[6:0], taken from the instruction register
- `funct3`  in  3  instruction[14:12]
- `funct7b5`  in  1  instruction[30]
- `zero`  in  1  ALU zero flag
- `immSrc`  out  2  sign-extender select: 00 I, 01 S, 10 B, 11 J
- `aluSrcA`  out  2  00 PC, 01 oldPC, 10 rs1 register
- `aluSrcB`  out  2  00 rs2 register, 01 immExt, 10 constant 4
- `resultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `adrSrc`  out  1  memory address select: 0 PC, 1 Result
- `aluControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `irWrite`, `pcWrite`, `regWrite`, `memWrite`  out  1 each  write enables
- `illegal`  out  1  high in DECODE when the opcode is unsupported
- `state`  out  4  current state (debug)

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10. Codes 11–15 go to FETCH on the next edge.
- State transitions:
  - FETCH→DECODE.
  - DECODE by `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other opcode → FETCH, with `illegal`=1.
  - MEMADR → MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER→ALUWB; EXECUTEI→ALUWB; JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
- Outputs per state. Any signal not listed is 0; aluOp defaults to 00.
  - FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10, pcUpdate=1.
  - DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (computes the branch/jump target).
  - MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00.
  - MEMREAD: resultSrc=00, adrSrc=1.
  - MEMWB: resultSrc=01, regWrite=1.
  - MEMWRITE: resultSrc=00, adrSrc=1, memWrite=1.
  - EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10.
  - ALUWB: resultSrc=00, regWrite=1.
  - JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1.
  - BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1.
- `pcWrite` = pcUpdate | (branch & zero).
- `immSrc` is combinational from `op` in every state:
  - lw / I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - anything else → 00
- ALU decoder:
  - aluOp 00 → add.
  - aluOp 01 → sub.
  - aluOp 10, by funct3:
    - 000 → sub if op[5] & funct7b5, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → add.
- Reset behaviour:
  - `rst`=1 at a rising edge loads FETCH.
  - While `rst` is high, irWrite, pcWrite, regWrite and memWrite are forced to 0.
  - Reset has priority over any transition, including mid-instruction (no write fires in the reset cycle).

## Timing
- Reset values: state=0, irWrite/pcWrite/regWrite/memWrite=0 (gated), illegal=0. Select outputs take their FETCH values: aluSrcB=10, resultSrc=10, aluControl=000.
- Outputs are Moore (decoded from `state`), except:
  - pcWrite also depends on `zero`;
  - immSrc and aluControl also depend on the current instruction fields.
- Cycles per instruction, FETCH through last state inclusive:
  - lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- Each write enable is high for exactly one cycle per instruction: irWrite in FETCH; regWrite in MEMWB or ALUWB; memWrite in MEMWRITE.
- pcWrite: FETCH, JAL, and BEQ only when `zero`=1.

## Test plan
- Reset:
  - hold `rst` 2 cycles with op=0100011 → state=0, all write enables 0.
  - release `rst` → irWrite=pcWrite=1 on the first cycle.
- lw (op=0000011):
  - state sequence 0,1,2,3,4,0.
  - immSrc=00 throughout.
  - regWrite=1 only in state 4, with resultSrc=01.
- sw (op=0100011):
  - sequence 0,1,2,5,0.
  - immSrc=01.
  - memWrite=1 only in state 5, with adrSrc=1.
- beq (op=1100011):
  - zero=1 → pcWrite=1 in state 10, aluControl=001, immSrc=10.
  - zero=0 → pcWrite=0.
  - then FETCH.
- R-type sub (op=0110011, funct3=000, funct7b5=1):
  - aluControl=001 in state 6.
  - regWrite in state 8.
  - with funct7b5=0 → aluControl=000.
- Illegal and reset mid-instruction:
  - op=1111111 → illegal=1 in DECODE, next state 0, no regWrite/memWrite.
  - lw with `rst` asserted in MEMREAD → state 0 next edge, regWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle of instruction fields, ALU flag and datapath controls exchanged
// between the multicycle control unit and the datapath.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] resultSrc;
  logic       adrSrc;
  logic [2:0] aluControl;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic       memWrite;
  logic       illegal;
  logic [3:0] state;

  // Control unit side.
  modport slave (
    input  op, funct3, funct7b5, zero,
    output immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
           irWrite, pcWrite, regWrite, memWrite, illegal, state
  );

  // Datapath side.
  modport master (
    output op, funct3, funct7b5, zero,
    input  immSrc, aluSrcA, aluSrcB, resultSrc, adrSrc, aluControl,
           irWrite, pcWrite, regWrite, memWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RISC-V core, with the immediate-format
// decoder and the ALU decoder.
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_we, reg_we, mem_we, illegal_s;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src;
  logic [1:0] imm_src;
  logic [2:0] alu_ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYP:      state_d = EXECUTER;
          OP_IALU:      state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (ctrl.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    illegal_s  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal_s = !(ctrl.op inside {OP_LW, OP_SW, OP_RTYP, OP_IALU, OP_JAL, OP_BEQ});
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_we     = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    reg_we = 1'b1;
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ctrl.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (ctrl.funct3)
          3'b000:  alu_ctrl = (ctrl.op[5] && ctrl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  // Write enables and the illegal flag are suppressed while reset is held,
  // so an instruction interrupted by reset never commits anything.
  assign ctrl.irWrite    = ir_we  & ~rst;
  assign ctrl.regWrite   = reg_we & ~rst;
  assign ctrl.memWrite   = mem_we & ~rst;
  assign ctrl.pcWrite    = (pc_update | (branch & ctrl.zero)) & ~rst;
  assign ctrl.illegal    = illegal_s & ~rst;
  assign ctrl.immSrc     = imm_src;
  assign ctrl.aluSrcA    = alu_src_a;
  assign ctrl.aluSrcB    = alu_src_b;
  assign ctrl.resultSrc  = result_src;
  assign ctrl.adrSrc     = adr_src;
  assign ctrl.aluControl = alu_ctrl;
  assign ctrl.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction class maps to an
// expected state path, and per-state output rules give the expected controls.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus.slave)
  );

  typedef struct packed {
    logic [1:0] immSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       adrSrc;
    logic [2:0] aluControl;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       memWrite;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         zmode;
    int         rst_idx;
    int         tag;
  } instr_t;

  int n_cmp = 0;
  int n_fail = 0;
  bit exp_valid = 0;
  int exp_state = 0;
  int seq[$];
  int idx;
  int cur_zmode, cur_rst_idx, cur_tag;
  instr_t dir_q[$];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // 0 lw, 1 sw, 2 R-type, 3 I-ALU, 4 jal, 5 beq, 6 unsupported
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return 5;
      default:    return 6;
    endcase
  endfunction

  function automatic exp_t model(input int s, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic z, input logic r);
    exp_t e;
    int aop, c;
    bit pcu, br;
    e = '0; aop = 0; pcu = 0; br = 0;
    c = classify(op);
    case (s)
      0:  begin e.irWrite = 1; e.aluSrcB = 2; e.resultSrc = 2; pcu = 1; end
      1:  begin e.aluSrcA = 1; e.aluSrcB = 1; e.illegal = (c == 6); end
      2:  begin e.aluSrcA = 2; e.aluSrcB = 1; end
      3:  e.adrSrc = 1;
      4:  begin e.resultSrc = 1; e.regWrite = 1; end
      5:  begin e.adrSrc = 1; e.memWrite = 1; end
      6:  begin e.aluSrcA = 2; aop = 2; end
      7:  begin e.aluSrcA = 2; e.aluSrcB = 1; aop = 2; end
      8:  e.regWrite = 1;
      9:  begin e.aluSrcA = 1; e.aluSrcB = 2; pcu = 1; end
      10: begin e.aluSrcA = 2; aop = 1; br = 1; end
      default: ;
    endcase
    e.pcWrite = pcu | (br & z);
    e.immSrc = (c == 1) ? 2'd1 : (c == 5) ? 2'd2 : (c == 4) ? 2'd3 : 2'd0;
    if (aop == 1) e.aluControl = 3'd1;
    else if (aop == 2) begin
      if (f3 == 3'd0)      e.aluControl = (op[5] && f7) ? 3'd1 : 3'd0;
      else if (f3 == 3'd2) e.aluControl = 3'd5;
      else if (f3 == 3'd6) e.aluControl = 3'd3;
      else if (f3 == 3'd7) e.aluControl = 3'd2;
      else                 e.aluControl = 3'd0;
    end
    if (r) begin
      e.irWrite = 0; e.pcWrite = 0; e.regWrite = 0; e.memWrite = 0; e.illegal = 0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      exp_t e;
      e = model(exp_state, bus.op, bus.funct3, bus.funct7b5, bus.zero, rst);
      chk("state",      int'(bus.state),      exp_state);
      chk("immSrc",     int'(bus.immSrc),     int'(e.immSrc));
      chk("aluSrcA",    int'(bus.aluSrcA),    int'(e.aluSrcA));
      chk("aluSrcB",    int'(bus.aluSrcB),    int'(e.aluSrcB));
      chk("resultSrc",  int'(bus.resultSrc),  int'(e.resultSrc));
      chk("adrSrc",     int'(bus.adrSrc),     int'(e.adrSrc));
      chk("aluControl", int'(bus.aluControl), int'(e.aluControl));
      chk("irWrite",    int'(bus.irWrite),    int'(e.irWrite));
      chk("pcWrite",    int'(bus.pcWrite),    int'(e.pcWrite));
      chk("regWrite",   int'(bus.regWrite),   int'(e.regWrite));
      chk("memWrite",   int'(bus.memWrite),   int'(e.memWrite));
      chk("illegal",    int'(bus.illegal),    int'(e.illegal));
    end
  end

  task automatic start_instr();
    instr_t in;
    int c;
    if (dir_q.size() > 0) in = dir_q.pop_front();
    else begin
      logic [6:0] legal [6];
      legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
      c = $urandom_range(0, 7);
      in.op = (c < 6) ? legal[c] : 7'($urandom);
      in.f3 = 3'($urandom);
      in.f7 = 1'($urandom);
      in.zmode = -1;
      in.rst_idx = -2;
      in.tag = 0;
    end
    bus.op = in.op;
    bus.funct3 = in.f3;
    bus.funct7b5 = in.f7;
    cur_zmode = in.zmode;
    cur_tag = in.tag;
    seq = '{0, 1};
    case (classify(in.op))
      0: seq = {seq, 2, 3, 4};
      1: seq = {seq, 2, 5};
      2: seq = {seq, 6, 8};
      3: seq = {seq, 7, 8};
      4: seq = {seq, 9, 8};
      5: seq = {seq, 10};
      default: ;
    endcase
    if (in.rst_idx == -2)
      cur_rst_idx = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, seq.size() - 1)) : -1;
    else
      cur_rst_idx = in.rst_idx;
    idx = 0;
    exp_state = 0;
  endtask

  // Called just after each rising edge: moves the model to the state the DUT now holds.
  task automatic advance();
    bit r_at_edge;
    r_at_edge = rst;
    if (r_at_edge) start_instr();
    else begin
      idx++;
      if (idx >= seq.size()) start_instr();
      else exp_state = seq[idx];
    end
    rst = (idx == cur_rst_idx) && !r_at_edge;
    bus.zero = (cur_zmode >= 0) ? 1'(cur_zmode) : 1'($urandom);
  endtask

  task automatic add_dir(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input int zmode, input int rst_idx, input int tag);
    instr_t in;
    in.op = op; in.f3 = f3; in.f7 = f7; in.zmode = zmode; in.rst_idx = rst_idx; in.tag = tag;
    dir_q.push_back(in);
  endtask

  initial begin
    rst = 1'b1;
    bus.op = 7'b0100011;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    cur_rst_idx = -1;
    cur_zmode = -1;
    cur_tag = 0;
    add_dir(7'b0000011, 3'b010, 1'b0, -1, -1, 1);
    add_dir(7'b0100011, 3'b010, 1'b0, -1, -1, 2);
    add_dir(7'b1100011, 3'b000, 1'b0,  1, -1, 3);
    add_dir(7'b1100011, 3'b000, 1'b0,  0, -1, 4);
    add_dir(7'b0110011, 3'b000, 1'b1, -1, -1, 5);
    add_dir(7'b0110011, 3'b000, 1'b0, -1, -1, 6);
    add_dir(7'b1111111, 3'b000, 1'b0, -1, -1, 7);
    add_dir(7'b0000011, 3'b010, 1'b0, -1,  3, 8);

    repeat (2) begin
      @(posedge clk); #1;
      exp_valid = 1;
      exp_state = 0;
      #2;
      chk("reset_state", int'(bus.state), 0);
      chk("reset_regWrite", int'(bus.regWrite | bus.memWrite | bus.irWrite | bus.pcWrite), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_instr();
    bus.zero = 1'b0;
    #2;
    chk("release_irWrite", int'(bus.irWrite), 1);
    chk("release_pcWrite", int'(bus.pcWrite), 1);

    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk); #1;
      advance();
      #2;
      case (cur_tag)
        1: if (idx == 4) begin
             chk("lw_state4", int'(bus.state), 4);
             chk("lw_regWrite", int'(bus.regWrite), 1);
             chk("lw_resultSrc", int'(bus.resultSrc), 1);
           end
        2: if (idx == 3) begin
             chk("sw_state5", int'(bus.state), 5);
             chk("sw_memWrite", int'(bus.memWrite), 1);
             chk("sw_adrSrc", int'(bus.adrSrc), 1);
             chk("sw_immSrc", int'(bus.immSrc), 1);
           end
        3: if (idx == 2) begin
             chk("beq_state10", int'(bus.state), 10);
             chk("beq_taken_pcWrite", int'(bus.pcWrite), 1);
             chk("beq_aluControl", int'(bus.aluControl), 1);
             chk("beq_immSrc", int'(bus.immSrc), 2);
           end
        4: if (idx == 2) chk("beq_nottaken_pcWrite", int'(bus.pcWrite), 0);
        5: if (idx == 2) begin
             chk("rsub_state6", int'(bus.state), 6);
             chk("rsub_aluControl", int'(bus.aluControl), 1);
           end
        6: if (idx == 2) chk("radd_aluControl", int'(bus.aluControl), 0);
        7: if (idx == 1) begin
             chk("illegal_state1", int'(bus.state), 1);
             chk("illegal_flag", int'(bus.illegal), 1);
           end
        8: if (idx == 3) begin
             chk("lwrst_state3", int'(bus.state), 3);
             chk("lwrst_regWrite", int'(bus.regWrite), 0);
           end
        default: ;
      endcase
    end

    exp_valid = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
